// File: rtl/alu_add_sub_seq.sv
// Sequential add/subtract unit: resolves SLICE bits per clock with a registered
// carry between slices. Optional abort input enabled by ALU_ADD_SUB_SEQ_ABORT_EN.
module alu_add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_sub_sel,
    input  logic             use_carry,
    input  logic             carry_in,
`ifdef ALU_ADD_SUB_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cy,
    output logic             ov,
    output logic             zero,
    output logic             sign
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    generate
        if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("alu_add_sub_seq: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] z_q;
    logic             c_q;
    logic             sub_q;
    logic             busy_q;
    logic             done_q;
    logic             cy_q;
    logic             ov_q;
    logic             zero_q;
    logic             sign_q;

    logic             abort_w;
    logic             accept;

`ifdef ALU_ADD_SUB_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Abort takes priority over a simultaneous start.
    assign accept = start & ~abort_w;

    // Current slice: per-bit propagate/generate with full lookahead to every bit.
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;
    logic [SLICE-1:0] sum;
    logic [WIDTH-1:0] z_d;
    logic             acc;
    logic             prod;

    always_comb begin
        a_s  = a_q[k_q*SLICE +: SLICE];
        b_s  = b_q[k_q*SLICE +: SLICE];
        p    = a_s ^ b_s;
        g    = a_s & b_s;
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = c_q;
        for (int i = 0; i < SLICE; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & c_q);
        end
        sum = p ^ c[SLICE-1:0];
        z_d = z_q;
        z_d[k_q*SLICE +: SLICE] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q     <= x;
                        b_q     <= y ^ {WIDTH{add_sub_sel}};
                        c_q     <= add_sub_sel ^ (use_carry & carry_in);
                        sub_q   <= add_sub_sel;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (abort_w) begin
                        k_q     <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        z_q <= z_d;
                        c_q <= c[SLICE];
                        if (k_q == K_LAST) begin
                            // Top slice: c[SLICE-1] is the carry into the MSB.
                            cy_q    <= c[SLICE] ^ sub_q;
                            ov_q    <= c[SLICE] ^ c[SLICE-1];
                            zero_q  <= (z_d == '0);
                            sign_q  <= z_d[WIDTH-1];
                            k_q     <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign cy   = cy_q;
    assign ov   = ov_q;
    assign zero = zero_q;
    assign sign = sign_q;

endmodule

// File: tb/tb_alu_add_sub_seq.sv
// Randomized and directed checks of alu_add_sub_seq against an arithmetic model.
module tb_alu_add_sub_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         add_sub_sel = 1'b0;
    logic         use_carry = 1'b0;
    logic         carry_in = 1'b0;
`ifdef ALU_ADD_SUB_SEQ_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         busy, done, cy, ov, zero, sign;
    logic [W-1:0] z;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] e_z;
    logic         e_cy, e_ov, e_zero, e_sign;

    always #5 clk = ~clk;

    alu_add_sub_seq #(.WIDTH(W), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .add_sub_sel(add_sub_sel), .use_carry(use_carry), .carry_in(carry_in),
`ifdef ALU_ADD_SUB_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .z(z), .cy(cy), .ov(ov), .zero(zero), .sign(sign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain integer arithmetic: unsigned for carry/borrow, signed for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic u, input logic ci);
        int cin, full, sa, sb, sr;
        cin = (u && ci) ? 1 : 0;
        sa  = $signed(a);
        sb  = $signed(b);
        if (!s) begin
            full = int'(a) + int'(b) + cin;
            e_cy = (full > 65535);
            sr   = sa + sb + cin;
        end else begin
            full = int'(a) - int'(b) - cin;
            e_cy = (full < 0);
            sr   = sa - sb - cin;
        end
        e_z    = full[W-1:0];
        e_ov   = (sr > 32767) || (sr < -32768);
        e_zero = (e_z == 0);
        e_sign = e_z[W-1];
    endtask

    task automatic check_res(input string tag);
        chk({tag, ".z"},    z,    e_z);
        chk({tag, ".cy"},   cy,   e_cy);
        chk({tag, ".ov"},   ov,   e_ov);
        chk({tag, ".zero"}, zero, e_zero);
        chk({tag, ".sign"}, sign, e_sign);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic u, input logic ci);
        int n, bc;
        model(a, b, s, u, ci);
        x = a; y = b; add_sub_sel = s; use_carry = u; carry_in = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Operands must already be captured; scramble them.
        x = W'($urandom); y = W'($urandom);
        add_sub_sel = 1'($urandom); use_carry = 1'($urandom); carry_in = 1'($urandom);
        n = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 16) begin
            tick();
            n++;
            if (busy) bc++;
        end
        chk({tag, ".lat"}, n, 4);
        chk({tag, ".busy_cyc"}, bc, 4);
        check_res(tag);
        tick();
        chk({tag, ".done_pulse"}, done, 0);
    endtask

    initial begin
        int n, ex;
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.z", z, 0);
        chk("rst.cy", cy, 0);
        chk("rst.ov", ov, 0);
        chk("rst.zero", zero, 0);
        chk("rst.sign", sign, 0);
        rst_n = 1'b1;
        tick();

        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op("sub_brw", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        do_op("adc",     16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1);
        do_op("sbc",     16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1);

        // Back-to-back: start held through the first op's DONE cycle.
        x = 16'h0F0F; y = 16'h0101; add_sub_sel = 1'b0; use_carry = 1'b0;
        start = 1'b1;
        tick();
        x = 16'h1234; y = 16'h1111;
        n = 0;
        while (!done && n < 16) begin tick(); n++; end
        chk("b2b1.lat", n, 4);
        chk("b2b1.z", z, 16'h1010);
        tick();
        start = 1'b0;
        x = W'($urandom); y = W'($urandom);
        chk("b2b2.busy", busy, 1);
        n = 0;
        while (!done && n < 16) begin tick(); n++; end
        chk("b2b2.lat", n, 4);
        model(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        check_res("b2b2");
        tick();

        // start pulsed while busy must be dropped.
        x = 16'h0100; y = 16'h0010; add_sub_sel = 1'b0; use_carry = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; x = 16'hAAAA;
        tick();
        start = 1'b0;
        n = 2;
        while (!done && n < 16) begin tick(); n++; end
        chk("ign.lat", n, 4);
        chk("ign.z", z, 16'h0110);
        ex = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (done) ex++; end
        chk("ign.extra_done", ex, 0);

        // Reset in the second RUN cycle, after an op that left flags set.
        do_op("pre_rst", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        x = 16'h8000; y = 16'h0001; add_sub_sel = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.busy", busy, 0);
        chk("mrst.done", done, 0);
        chk("mrst.z", z, 0);
        chk("mrst.cy", cy, 0);
        chk("mrst.ov", ov, 0);
        chk("mrst.zero", zero, 0);
        chk("mrst.sign", sign, 0);
        #1 rst_n = 1'b1;
        tick();
        do_op("post_rst", 16'h1357, 16'h0246, 1'b1, 1'b0, 1'b0);

`ifdef ALU_ADD_SUB_SEQ_ABORT_EN
        do_op("pre_abt", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        x = 16'h0003; y = 16'h0004; add_sub_sel = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt.busy", busy, 0);
        chk("abt.done", done, 0);
        chk("abt.cy", cy, e_cy);
        chk("abt.ov", ov, e_ov);
        chk("abt.zero", zero, e_zero);
        chk("abt.sign", sign, e_sign);
        ex = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done) ex++; end
        chk("abt.no_done", ex, 0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abt_start.busy", busy, 0);
        do_op("post_abt", 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: b = a;
                2: a = 16'h8000;
                default: ;
            endcase
            do_op("rnd", a, b, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
